axi4_str_sink: RTL and testbench

// - AXI4-Stream consumer at the read end of axi4_str_fifo, in the m_axis_clk domain.
// - Throttles m_axis_tready with a rotating 8-bit pattern and counts accepted beats.
// - Checks each beat against the expected next value: incrementing counter or Galois LFSR.
// - Reports error count, first mismatch and completion. Used as a bench/BIST reader for the FIFO.

---
 rtl/axi4_str_sink.sv | 117 +++++++++++
 tb/tb_axi4_str_sink.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi4_str_sink.sv
// AXI4-Stream checking sink: throttles tready with a rotating duty mask, counts
// accepted beats and checks each one against an incrementing or LFSR sequence.
module axi4_str_sink #(
  parameter int unsigned          DATA_WDTH = 8,
  parameter int unsigned          CNT_WDTH  = 16,
  parameter logic [DATA_WDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                 m_axis_clk,
  input  logic                 m_axis_aresetn,
  input  logic [DATA_WDTH-1:0] m_axis_tdata,
  input  logic                 m_axis_tvalid,
  output logic                 m_axis_tready,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WDTH-1:0]  num_beats,
  input  logic                 mode,
  input  logic [7:0]           ready_pattern,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WDTH-1:0]  beat_cnt,
  output logic [CNT_WDTH-1:0]  err_cnt,
  output logic [DATA_WDTH-1:0] err_exp,
  output logic [DATA_WDTH-1:0] err_got
);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;

  state_t                 state;
  logic [7:0]             pat_q;
  logic                   mode_q;
  logic [CNT_WDTH-1:0]    num_q;
  logic [DATA_WDTH-1:0]   exp_q;
  logic                   beat;

  function automatic logic [DATA_WDTH-1:0] nxt(input logic [DATA_WDTH-1:0] d, input logic m);
    if (m) return (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
    else   return d + DATA_WDTH'(1);
  endfunction

  assign beat = m_axis_tvalid & m_axis_tready;
  assign busy = (state != IDLE);

  // NOTE: every register here is sequential state, so all assignments use <=;
  // mixing in = would make later reads in this block see same-cycle values.
  always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state         <= IDLE;
      pat_q         <= '0;
      mode_q        <= 1'b0;
      num_q         <= '0;
      exp_q         <= '0;
      m_axis_tready <= 1'b0;
      done          <= 1'b0;
      beat_cnt      <= '0;
      err_cnt       <= '0;
      err_exp       <= '0;
      err_got       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          m_axis_tready <= 1'b0;
          if (start && !abort) begin
            num_q    <= num_beats;
            mode_q   <= mode;
            pat_q    <= (ready_pattern == 8'h00) ? 8'hFF : ready_pattern;
            beat_cnt <= '0;
            err_cnt  <= '0;
            err_exp  <= '0;
            err_got  <= '0;
            if (num_beats == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC, CHECK: begin
          m_axis_tready <= pat_q[0];
          pat_q         <= {pat_q[0], pat_q[7:1]};
          if (beat) begin
            // The checker always re-seeds from the received beat, so a dropped
            // beat costs a single error instead of derailing the whole run.
            exp_q    <= nxt(m_axis_tdata, mode_q);
            beat_cnt <= beat_cnt + CNT_WDTH'(1);
            if (state == CHECK && m_axis_tdata != exp_q) begin
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_WDTH'(1);
              if (err_cnt == '0) begin
                err_exp <= exp_q;
                err_got <= m_axis_tdata;
              end
            end
            if ((beat_cnt + CNT_WDTH'(1)) == num_q) begin
              state         <= DONE;
              m_axis_tready <= 1'b0;
              done          <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end
        DONE: begin
          m_axis_tready <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (abort && state != IDLE) begin
        state         <= IDLE;
        m_axis_tready <= 1'b0;
        done          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_str_sink.sv
// Directed/randomized bench for axi4_str_sink: a cycle-level FIFO source plus a
// sequence-level reference model of the tready duty cycle and the beat checker.
module tb_axi4_str_sink;

  logic        clk;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        start;
  logic        abort;
  logic [15:0] num_beats;
  logic        mode;
  logic [7:0]  ready_pattern;
  logic        busy;
  logic        done;
  logic [15:0] beat_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  err_exp;
  logic [7:0]  err_got;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  src[$];

  axi4_str_sink dut (
    .m_axis_clk     (clk),
    .m_axis_aresetn (rst_n),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .start          (start),
    .abort          (abort),
    .num_beats      (num_beats),
    .mode           (mode),
    .ready_pattern  (ready_pattern),
    .busy           (busy),
    .done           (done),
    .beat_cnt       (beat_cnt),
    .err_cnt        (err_cnt),
    .err_exp        (err_exp),
    .err_got        (err_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_nxt(input logic [7:0] d, input bit m);
    int v;
    if (!m) begin
      v = (int'(d) + 1) % 256;
      return v[7:0];
    end
    return d[0] ? ((d >> 1) ^ 8'hB8) : (d >> 1);
  endfunction

  task automatic chk_zero(input string pfx);
    check({pfx, "_tready"}, tready, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_beat_cnt"}, beat_cnt, 0);
    check({pfx, "_err_cnt"}, err_cnt, 0);
    check({pfx, "_err_exp"}, err_exp, 0);
    check({pfx, "_err_got"}, err_got, 0);
  endtask

  // One run: start pulse, then per-cycle FIFO emulation and output checks.
  // abort_at/restart_at/reset_at are cycle indices after the start edge (-1 = unused).
  task automatic run(input string name, input int num, input bit md, input logic [7:0] pat_in,
                     input int gap_pct, input int abort_at, input int restart_at, input int reset_at);
    logic [7:0] pat;
    logic [7:0] acc[$];
    logic [7:0] e, f_exp, f_got;
    int         f, idx, beats, n_err;
    bit         f_set, ab, finished;
    logic       exp_rdy;
    pat = (pat_in == 8'h00) ? 8'hFF : pat_in;
    @(negedge clk);
    num_beats = 16'(num); mode = md; ready_pattern = pat_in; start = 1'b1;
    @(posedge clk);
    f_set = (num == 0); f = 0; idx = 0; beats = 0; finished = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; tvalid = 1'b0;
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero({name, "_async_rst"});
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      ab = (abort_at >= 0) && (k > abort_at);
      exp_rdy = (!ab && k >= 1 && beats < num) ? pat[(k - 1) % 8] : 1'b0;
      check({name, "_tready"}, tready, exp_rdy);
      check({name, "_done"}, done, f_set && !ab && k == f);
      check({name, "_busy"}, busy, !ab && !(f_set && k > f));
      if ((ab && k >= abort_at + 3) || (!ab && f_set && k >= f + 2)) begin
        finished = 1;
        break;
      end
      if (k == abort_at) abort = 1'b1;
      if (k == restart_at) begin start = 1'b1; num_beats = 16'd1; end
      if (idx < src.size() && $urandom_range(99) >= 32'(gap_pct)) begin
        tvalid = 1'b1;
        tdata  = src[idx];
      end
      if (tvalid && tready) begin
        acc.push_back(src[idx]);
        idx++;
        beats++;
        if (beats == num) begin f_set = 1; f = k + 1; end
      end
      @(posedge clk);
    end
    tvalid = 1'b0;
    check({name, "_finished"}, 32'(finished), 1);
    n_err = 0; f_exp = 8'h00; f_got = 8'h00;
    for (int i = 1; i < acc.size(); i++) begin
      e = model_nxt(acc[i-1], md);
      if (acc[i] != e) begin
        if (n_err == 0) begin f_exp = e; f_got = acc[i]; end
        n_err++;
      end
    end
    if (abort_at < 0) check({name, "_accepted"}, acc.size(), num);
    check({name, "_beat_cnt"}, beat_cnt, acc.size());
    check({name, "_err_cnt"}, err_cnt, n_err);
    check({name, "_err_exp"}, err_exp, f_exp);
    check({name, "_err_got"}, err_got, f_got);
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b1; tdata = '0; tvalid = 1'b0; start = 1'b0; abort = 1'b0;
    num_beats = '0; mode = 1'b0; ready_pattern = '0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    src.delete();
    for (int i = 1; i <= 8; i++) src.push_back(8'(i));
    run("incr", 8, 1'b0, 8'hFF, 0, -1, -1, -1);

    src = '{8'hBA, 8'hBB, 8'hBD, 8'hBE};
    run("mismatch", 4, 1'b0, 8'hFF, 0, -1, -1, -1);

    src.delete();
    for (int i = 0; i < 16; i++) src.push_back(8'(8'h30 + i));
    run("throttle", 16, 1'b0, 8'b0000_0101, 0, -1, 5, -1);

    src.delete();
    v = 8'h01;
    for (int i = 0; i < 100; i++) begin src.push_back(v); v = model_nxt(v, 1'b1); end
    run("lfsr", 100, 1'b1, 8'($urandom), 30, -1, -1, -1);
    src[50] = src[50] ^ 8'h10;
    run("lfsr_flip", 100, 1'b1, 8'hFF, 20, -1, -1, -1);

    src.delete();
    for (int i = 0; i < 32; i++) src.push_back(8'($urandom));
    run("rand_incr", 32, 1'b0, 8'($urandom), 25, -1, -1, -1);
    run("one_beat", 1, 1'b1, 8'h00, 0, -1, -1, -1);
    run("zero_beats", 0, 1'b0, 8'hFF, 0, -1, -1, -1);

    src.delete();
    for (int i = 0; i < 20; i++) src.push_back(8'(i == 2 ? 8'h77 : 8'h10 + i));
    run("abort", 20, 1'b0, 8'hFF, 0, 6, -1, -1);

    src.delete();
    for (int i = 0; i < 100; i++) src.push_back(8'(i == 2 ? 8'hEE : i));
    run("reset_mid", 100, 1'b0, 8'hFF, 0, -1, -1, 20);

    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(8'(8'hF8 + i));
    run("after_reset", 12, 1'b0, 8'b1011_0110, 10, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
